// File: rtl/pipe_elastic_chain_t.sv
// Elastic register chain: DEPTH valid/ready stages with bubble
// collapsing and a synchronous flush that clears every valid bit.
module pipe_elastic_chain_t #(
  parameter int                   BIT_WIDTH     = 32,
  parameter int                   DEPTH         = 2,
  parameter logic [BIT_WIDTH-1:0] DEFAULT_VALUE = '0,
  parameter int                   OCC_W         = $clog2(DEPTH+1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FLUSH,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [BIT_WIDTH-1:0] IN_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [BIT_WIDTH-1:0] OUT_DATA,
  output logic [OCC_W-1:0]     OCCUPANCY
);

  logic [DEPTH-1:0]     vld_q;
  logic [DEPTH-1:0]     vld_d;
  logic [DEPTH-1:0]     mv;
  logic [BIT_WIDTH-1:0] dat_q [DEPTH];
  logic [BIT_WIDTH-1:0] dat_d [DEPTH];
  logic [OCC_W-1:0]     occ;
  logic                 accept;

  // A stage moves if its successor is empty or moving itself
  always_comb begin
    mv = '0;
    mv[DEPTH-1] = vld_q[DEPTH-1] & OUT_READY;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      mv[i] = vld_q[i] & (~vld_q[i+1] | mv[i+1]);
    end
  end

  assign IN_READY  = ~FLUSH & (~vld_q[0] | mv[0]);
  assign accept    = IN_VALID & IN_READY;
  assign OUT_VALID = vld_q[DEPTH-1] & ~FLUSH;
  assign OUT_DATA  = dat_q[DEPTH-1];

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (FLUSH) begin
      vld_d = '0;
    end else begin
      if (accept) begin
        vld_d[0] = 1'b1;
        dat_d[0] = IN_DATA;
      end else if (mv[0]) begin
        vld_d[0] = 1'b0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (mv[i-1]) begin
          vld_d[i] = 1'b1;
          dat_d[i] = dat_q[i-1];
        end else if (mv[i]) begin
          vld_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= DEFAULT_VALUE;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= dat_d[i];
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(vld_q[i]);
    end
  end

  assign OCCUPANCY = occ;

  a_in_hold: assert property (
    @(posedge CLK) disable iff (RST)
    IN_VALID && !IN_READY && !FLUSH |=> IN_VALID);

  a_out_hold: assert property (
    @(posedge CLK) disable iff (RST)
    OUT_VALID && !OUT_READY && !FLUSH |=> OUT_VALID);

endmodule

// File: tb/tb_pipe_elastic_chain_t.sv
// Directed bench for the elastic chain at DEPTH 2, 3 and 1,
// plus a scoreboarded random handshake run on the 1-deep chain.
module tb_pipe_elastic_chain_t;

  logic CLK;
  logic RST;

  logic       a_fl, a_iv, a_ir, a_ov, a_or;
  logic [7:0] a_id, a_od;
  logic [1:0] a_occ;

  logic       b_fl, b_iv, b_ir, b_ov, b_or;
  logic [7:0] b_id, b_od;
  logic [1:0] b_occ;

  logic       c_fl, c_iv, c_ir, c_ov, c_or;
  logic [7:0] c_id, c_od;
  logic [0:0] c_occ;

  int n_chk;
  int n_err;

  pipe_elastic_chain_t #(
    .BIT_WIDTH(8), .DEPTH(2), .DEFAULT_VALUE(8'h5A)
  ) u_a (
    .CLK(CLK), .RST(RST), .FLUSH(a_fl),
    .IN_VALID(a_iv), .IN_READY(a_ir), .IN_DATA(a_id),
    .OUT_VALID(a_ov), .OUT_READY(a_or), .OUT_DATA(a_od),
    .OCCUPANCY(a_occ)
  );

  pipe_elastic_chain_t #(
    .BIT_WIDTH(8), .DEPTH(3), .DEFAULT_VALUE(8'h00)
  ) u_b (
    .CLK(CLK), .RST(RST), .FLUSH(b_fl),
    .IN_VALID(b_iv), .IN_READY(b_ir), .IN_DATA(b_id),
    .OUT_VALID(b_ov), .OUT_READY(b_or), .OUT_DATA(b_od),
    .OCCUPANCY(b_occ)
  );

  pipe_elastic_chain_t #(
    .BIT_WIDTH(8), .DEPTH(1), .DEFAULT_VALUE(8'h00)
  ) u_c (
    .CLK(CLK), .RST(RST), .FLUSH(c_fl),
    .IN_VALID(c_iv), .IN_READY(c_ir), .IN_DATA(c_id),
    .OUT_VALID(c_ov), .OUT_READY(c_or), .OUT_DATA(c_od),
    .OCCUPANCY(c_occ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] seq;
  logic       in_f, out_f;

  initial begin
    n_chk = 0;
    n_err = 0;
    RST = 1'b1;
    a_fl = 0; a_iv = 0; a_or = 0; a_id = '0;
    b_fl = 0; b_iv = 0; b_or = 0; b_id = '0;
    c_fl = 0; c_iv = 0; c_or = 0; c_id = '0;
    #2;
    check("rst_ov", a_ov, 0);
    check("rst_od", a_od, 8'h5A);
    check("rst_occ", a_occ, 0);
    check("rst_ir", a_ir, 1);
    @(posedge CLK);
    #2 RST = 1'b0;
    step();

    // Streaming through DEPTH=2 with OUT_READY high
    a_iv = 1; a_id = 8'h11; a_or = 1;
    #1 check("t1_ir", a_ir, 1);
    step();
    check("t1_occ1", a_occ, 1);
    check("t1_ov0", a_ov, 0);
    a_id = 8'h22;
    step();
    check("t1_ov", a_ov, 1);
    check("t1_d11", a_od, 8'h11);
    check("t1_occ2", a_occ, 2);
    a_id = 8'h33;
    step();
    check("t1_d22", a_od, 8'h22);
    check("t1_occ2b", a_occ, 2);
    a_iv = 0;
    step();
    check("t1_d33", a_od, 8'h33);
    check("t1_occ1b", a_occ, 1);
    step();
    check("t1_empty", a_ov, 0);
    check("t1_occ0", a_occ, 0);
    a_or = 0;

    // Fill DEPTH=3 under backpressure, then drain
    b_iv = 1; b_or = 0;
    b_id = 8'hA0; step();
    check("t2_occ1", b_occ, 1);
    b_id = 8'hA1; step();
    check("t2_occ2", b_occ, 2);
    b_id = 8'hA2; step();
    b_iv = 0;
    check("t2_occ3", b_occ, 3);
    #1 check("t2_ir0", b_ir, 0);
    check("t2_ovf", b_ov, 1);
    check("t2_hdA0", b_od, 8'hA0);
    step();
    check("t2_hold", b_od, 8'hA0);
    check("t2_occh", b_occ, 3);
    b_or = 1;
    step();
    check("t2_A1", b_od, 8'hA1);
    step();
    check("t2_A2", b_od, 8'hA2);
    step();
    check("t2_drn", b_ov, 0);
    check("t2_occ0", b_occ, 0);
    b_or = 0;

    // Bubble collapse with OUT_READY low
    b_iv = 1; b_id = 8'h05;
    step();
    b_iv = 0;
    step();
    check("t3_nov", b_ov, 0);
    step();
    check("t3_ov", b_ov, 1);
    check("t3_d5", b_od, 8'h05);
    b_iv = 1; b_id = 8'h06;
    step();
    b_iv = 0;
    step();
    step();
    check("t3_occ2", b_occ, 2);
    check("t3_ir", b_ir, 1);
    check("t3_d5b", b_od, 8'h05);
    b_or = 1;
    step();
    check("t3_d6", b_od, 8'h06);
    step();
    check("t3_drn", b_occ, 0);
    b_or = 0;

    // Flush a full DEPTH=2 chain
    a_or = 0; a_iv = 1; a_id = 8'h01;
    step();
    a_id = 8'h02;
    step();
    a_iv = 0;
    check("t4_occ2", a_occ, 2);
    check("t4_ir0", a_ir, 0);
    check("t4_d1", a_od, 8'h01);
    a_fl = 1; a_iv = 1; a_id = 8'h09;
    #1 check("t4_flov", a_ov, 0);
    check("t4_flir", a_ir, 0);
    step();
    a_fl = 0; a_iv = 0;
    check("t4_occ0", a_occ, 0);
    check("t4_ov0", a_ov, 0);
    check("t4_dkeep", a_od, 8'h01);
    step();
    check("t4_no9", a_occ, 0);

    // Asynchronous reset between edges
    a_iv = 1; a_id = 8'h03;
    step();
    a_id = 8'h04;
    step();
    a_iv = 0;
    check("t5_pre", a_occ, 2);
    #2 RST = 1'b1;
    #1;
    check("t5_ov", a_ov, 0);
    check("t5_od", a_od, 8'h5A);
    check("t5_occ", a_occ, 0);
    check("t5_ir", a_ir, 1);
    #1 RST = 1'b0;
    a_iv = 1; a_id = 8'h77; a_or = 1;
    step();
    a_iv = 0;
    check("t5_acc", a_occ, 1);
    step();
    check("t5_ov1", a_ov, 1);
    check("t5_d77", a_od, 8'h77);
    step();
    check("t5_drn", a_ov, 0);

    // Random handshake against a queue model, DEPTH=1
    seq = 8'h00;
    for (int k = 0; k < 1000; k++) begin
      if (!c_iv) begin
        c_iv = 1'($urandom_range(0, 1));
        if (c_iv) begin
          c_id = seq;
          seq = seq + 8'd1;
        end
      end
      c_or = 1'($urandom_range(0, 1));
      #1;
      check("t6_occ", c_occ, q.size());
      check("t6_ov", c_ov, q.size() != 0);
      check("t6_ir", c_ir, (q.size() == 0) || c_or);
      out_f = c_ov & c_or;
      in_f  = c_iv & c_ir;
      if (out_f && q.size() != 0) begin
        check("t6_od", c_od, q[0]);
        void'(q.pop_front());
      end
      if (in_f) q.push_back(c_id);
      step();
      if (in_f) c_iv = 0;
    end
    c_iv = 0; c_or = 1;
    step();
    check("t6_drn", c_occ, 0);
    check("t6_q", q.size() - (out_f ? 0 : 0), c_occ + q.size());

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
